// File: rtl/audio_output_stage.sv
// Output stage: scales, mutes and saturates filter samples to a codec word,
// buffers them in a small FIFO drained over ready/valid, and tracks clipping.
module audio_output_stage #(
  parameter int DEPTH     = 8,
  parameter int OUT_WIDTH = 24,
  parameter int VOL_BITS  = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [31:0]                  in_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [VOL_BITS-1:0]          volume_i,
  input  logic                         mute_i,
  input  logic                         flush_i,
  input  logic                         clear_clip_i,
  output logic [OUT_WIDTH-1:0]         out_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         clip_flag_o,
  output logic [15:0]                  clip_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // True when the scaled value does not fit in OUT_WIDTH signed bits.
  function automatic logic needs_sat(input logic [31:0] scaled);
    logic [31-OUT_WIDTH+1:0] top;
    top = scaled[31:OUT_WIDTH-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_word(input logic [31:0] scaled);
    logic [OUT_WIDTH-1:0] w;
    if (!needs_sat(scaled)) begin
      w = scaled[OUT_WIDTH-1:0];
    end else if (scaled[31]) begin
      w = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      w = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
    return w;
  endfunction

  logic [OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 clip_flag_q, clip_flag_d;
  logic [15:0]          clip_count_q, clip_count_d;

  logic [31:0]          scaled_s;
  logic [OUT_WIDTH-1:0] wdata_s;
  logic                 push_s, pop_s, clip_s;

  assign in_ready_o   = (level_q != LW'(DEPTH));
  assign out_valid_o  = (level_q != {LW{1'b0}});
  assign out_o        = out_valid_o ? mem_q[rd_ptr_q] : {OUT_WIDTH{1'b0}};
  assign level_o      = level_q;
  assign clip_flag_o  = clip_flag_q;
  assign clip_count_o = clip_count_q;

  // Datapath and handshake qualification; flush suppresses both transfers.
  always_comb begin
    scaled_s = $signed(in_i) >>> volume_i;
    push_s   = in_valid_i & in_ready_o & ~flush_i;
    pop_s    = out_valid_o & out_ready_i & ~flush_i;
    clip_s   = push_s & ~mute_i & needs_sat(scaled_s);
    if (mute_i) begin
      wdata_s = {OUT_WIDTH{1'b0}};
    end else begin
      wdata_s = sat_word(scaled_s);
    end
  end

  // Pointer, occupancy and clip accounting next state.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    level_d      = level_q;
    clip_flag_d  = clip_flag_q;
    clip_count_d = clip_count_q;
    if (flush_i) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      level_d  = {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    // Clear has priority over a same-cycle saturated push.
    if (clear_clip_i) begin
      clip_flag_d  = 1'b0;
      clip_count_d = 16'h0000;
    end else if (clip_s) begin
      clip_flag_d = 1'b1;
      if (clip_count_q != 16'hFFFF) begin
        clip_count_d = clip_count_q + 16'd1;
      end else begin
        clip_count_d = clip_count_q;
      end
    end else begin
      clip_flag_d  = clip_flag_q;
      clip_count_d = clip_count_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q     <= {PW{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      level_q      <= {LW{1'b0}};
      clip_flag_q  <= 1'b0;
      clip_count_q <= 16'h0000;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      clip_flag_q  <= clip_flag_d;
      clip_count_q <= clip_count_d;
    end
  end

  // Sample storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {OUT_WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

endmodule
